act_stream_unit: RTL

Parametrised multi-lane activation stage for the DNN datapath. It replaces the fixed 4-lane, ReLU-only register stage with a valid/ready streaming block. The block supports:
- a configurable lane count;
- four run-time activation modes;
- signed saturation to a narrower output width;
- a skid buffer for back-pressure;
- frame counting.

It sits between the neuron accumulator outputs and the next layer's input buffer.

---
 rtl/act_stream_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/act_stream_unit.sv
// -----------------------------------------------------------------------------
// act_stream_unit
//
// Multi-lane activation stage with valid/ready streaming. Each accepted beat
// runs through a per-lane activation function selected at run time. The result
// is saturated to OUT_W bits and held in a two-entry buffer: the output
// register OUT plus a skid register SKID. The buffer absorbs one cycle of
// downstream back-pressure, so in_ready is a pure register output.
//
// Optional feature macro: ACT_SAT_STATS_EN
//   defined   -> sat_cnt counts accepted beats with any saturated lane,
//                and sticks at 0xFFFF.
//   undefined -> sat_cnt is tied to zero and no detect logic exists.
//
// Parameters
//   LANES        parallel values per beat
//   IN_W         signed input width per lane
//   OUT_W        signed output width per lane (2 <= OUT_W <= IN_W)
//   LEAKY_SHIFT  arithmetic right shift applied to negatives in leaky mode
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   cfg_we                 load cfg_mode / cfg_clamp into config registers
//   cfg_mode [1:0]         0 bypass, 1 ReLU, 2 leaky ReLU, 3 clamped ReLU
//   cfg_clamp [OUT_W-2:0]  unsigned upper bound for mode 3
//   in_valid/in_ready      input handshake
//   in_data                lane i at [i*IN_W +: IN_W]
//   in_last                frame end marker, travels with the beat
//   out_valid/out_ready    output handshake
//   out_data               lane i at [i*OUT_W +: OUT_W]
//   out_last               frame end marker of the presented beat
//   frame_cnt [15:0]       transfers with out_last=1 (wraps)
//   sat_cnt [15:0]         saturated-beat count (see macro above)
// -----------------------------------------------------------------------------
module act_stream_unit #(
  parameter int LANES       = 4,
  parameter int IN_W        = 12,
  parameter int OUT_W       = 12,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_mode,
  input  logic [OUT_W-2:0]       cfg_clamp,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   out_last,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            sat_cnt
);

  // Representable output range, expressed at input width for comparison.
  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;

  // Config registers
  logic [1:0]       mode_reg;
  logic [OUT_W-2:0] clamp_reg;

  // Buffer state
  logic                   out_valid_reg;
  logic [LANES*OUT_W-1:0] out_data_reg;
  logic                   out_last_reg;
  logic                   skid_valid_reg;
  logic [LANES*OUT_W-1:0] skid_data_reg;
  logic                   skid_last_reg;
  logic [15:0]            frame_cnt_reg;

  logic                   accept;
  logic                   xfer;
  logic [LANES*OUT_W-1:0] beat_data;

  // The clamp is at most 2^(OUT_W-1)-1, so it is always a positive IN_W value.
  logic signed [IN_W-1:0] clamp_ext;
  assign clamp_ext = {{(IN_W-OUT_W+1){1'b0}}, clamp_reg};

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid_reg && out_ready;

`ifdef ACT_SAT_STATS_EN
  logic [LANES-1:0] lane_sat;
`endif

  // ---------------------------------------------------------------------------
  // Per-lane activation and narrowing
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [IN_W-1:0]  x;
      logic signed [IN_W-1:0]  y;
      logic signed [OUT_W-1:0] z;
      logic                    x_neg;
      logic                    x_zero;

      assign x      = in_data[gi*IN_W +: IN_W];
      assign x_neg  = x[IN_W-1];
      assign x_zero = (x == '0);

      always_comb begin
        y = x;
        case (mode_reg)
          2'd0: y = x;
          2'd1: y = (x_neg || x_zero) ? '0 : x;
          // Arithmetic shift rounds toward -inf, so small negatives stay -1.
          2'd2: y = x_neg ? (x >>> LEAKY_SHIFT) : x;
          default: begin
            if (x_neg || x_zero)
              y = '0;
            else if (x > clamp_ext)
              y = clamp_ext;
            else
              y = x;
          end
        endcase
      end

      always_comb begin
        z = y[OUT_W-1:0];
        if (y > SAT_MAX)
          z = SAT_MAX[OUT_W-1:0];
        else if (y < SAT_MIN)
          z = SAT_MIN[OUT_W-1:0];
      end

`ifdef ACT_SAT_STATS_EN
      // Clamped mode-3 results never exceed SAT_MAX, so the clamp is
      // never reported as saturation.
      assign lane_sat[gi] = (y > SAT_MAX) || (y < SAT_MIN);
`endif

      assign beat_data[gi*OUT_W +: OUT_W] = z;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Config registers: a beat accepted together with cfg_we was already
  // computed from the old values above, so a plain register load is enough.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg  <= 2'd1;
      clamp_reg <= '1;
    end else if (cfg_we) begin
      mode_reg  <= cfg_mode;
      clamp_reg <= cfg_clamp;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry buffer. SKID only fills while OUT is stalled. Accept is
  // impossible while SKID is full, so SKID->OUT never competes with a new beat.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_last_reg  <= 1'b0;
    end else begin
      if (xfer || !out_valid_reg) begin
        if (skid_valid_reg) begin
          out_valid_reg  <= 1'b1;
          out_data_reg   <= skid_data_reg;
          out_last_reg   <= skid_last_reg;
          skid_valid_reg <= 1'b0;
        end else if (accept) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= beat_data;
          out_last_reg  <= in_last;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= beat_data;
        skid_last_reg  <= in_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt_reg <= '0;
    else if (xfer && out_last_reg)
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
  end

`ifdef ACT_SAT_STATS_EN
  logic [15:0] sat_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt_reg <= '0;
    else if (accept && (|lane_sat) && (sat_cnt_reg != 16'hFFFF))
      sat_cnt_reg <= sat_cnt_reg + 16'd1;
  end

  assign sat_cnt = sat_cnt_reg;
`else
  assign sat_cnt = 16'd0;
`endif

  assign in_ready  = !skid_valid_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule
